jzjpcc_writeback: RTL



---
 rtl/jzjpcc_pkg.sv | 35 +++
 rtl/jzjpcc_loadextract.sv | 40 ++++
 rtl/jzjpcc_writeback.sv | 138 +++++++++++++
 3 files changed

// File: rtl/jzjpcc_pkg.sv
// ----------------------------------------------------------------------------
// jzjpcc_pkg
// Shared types and constants for the jzjpcc pipeline stages.
//   wbSel_t     : writeback source select (ALU / load / immediate / reserved)
//   LB..LHU     : funct3 encodings of the load instructions
//   wbBundle_t  : memory-stage bundle presented to the writeback stage
// ----------------------------------------------------------------------------
package jzjpcc_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_IMM  = 2'b10,
    WB_RSVD = 2'b11   // reserved; resolved as ALU
  } wbSel_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rdAddr;
    logic        rdWE;
    wbSel_t      wbSel;
    logic [2:0]  funct3;
    logic [1:0]  addrLow;
    logic [31:0] readData;
    logic [31:0] aluResult;
    logic [31:0] immediate;
  } wbBundle_t;

endpackage

// File: rtl/jzjpcc_loadextract.sv
// ----------------------------------------------------------------------------
// jzjpcc_loadextract
// Combinational load-data extraction: picks the byte/half/word addressed by a
// load out of an aligned memory word and sign- or zero-extends it.
//   funct3  in  3   load type (LB/LH/LW/LBU/LHU; others pass the word through)
//   addrLow in  2   byte address bits [1:0]; bit 0 ignored for halfwords
//   word    in  32  aligned word from data memory
//   value   out 32  extracted, extended load value
// ----------------------------------------------------------------------------
module jzjpcc_loadextract
  import jzjpcc_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addrLow,
  input  logic [31:0] word,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addrLow, 3'b000} +: 8];
  // Misaligned halfwords are trapped upstream, so only bit 1 picks the half.
  assign half_sel = addrLow[1] ? word[31:16] : word[15:0];

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred when a new funct3 arm is added later.
    value = word;
    case (funct3)
      LB:      value = {{24{byte_sel[7]}}, byte_sel};
      LBU:     value = {24'h000000, byte_sel};
      LH:      value = {{16{half_sel[15]}}, half_sel};
      LHU:     value = {16'h0000, half_sel};
      LW:      value = word;
      default: value = word;   // illegal loads are trapped upstream
    endcase
  end

endmodule

// File: rtl/jzjpcc_writeback.sv
// ----------------------------------------------------------------------------
// jzjpcc_writeback
// Final pipeline stage: registers the memory-stage bundle, selects the
// writeback value (ALU result, extracted load data, or LUI immediate) and
// drives the register-file write port plus the forwarding bus into execute.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   stall, flush        hazard control (flush > stall > capture)
//   mem*                memory-stage bundle
//   rdWE/rdAddr/rdData  register-file write port (registered)
//   fwdValid/Addr/Data  forwarding bus, identical to the write port
//   retireCount         retired-instruction counter
//
// Build option: define JZJPCC_WB_RETIRE_COUNTER_EN to build the retire
// counter; otherwise retireCount is tied to 0.
// ----------------------------------------------------------------------------
module jzjpcc_writeback
  import jzjpcc_pkg::*;
#(
  parameter int RESET_PC_UNUSED = 0,
  parameter int RETIRE_CNT_W    = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    memValid,
  input  logic [4:0]              memRdAddr,
  input  logic                    memRdWE,
  input  logic [1:0]              memWbSel,
  input  logic [2:0]              memFunct3,
  input  logic [1:0]              memAddrLow,
  input  logic [31:0]             memReadData,
  input  logic [31:0]             memAluResult,
  input  logic [31:0]             memImmediate,
  output logic                    rdWE,
  output logic [4:0]              rdAddr,
  output logic [31:0]             rdData,
  output logic                    fwdValid,
  output logic [4:0]              fwdAddr,
  output logic [31:0]             fwdData,
  output logic [RETIRE_CNT_W-1:0] retireCount
);

  // Parameter kept only for a uniform parameter list across stages.
  logic [31:0] unused_reset_pc;
  assign unused_reset_pc = 32'(RESET_PC_UNUSED);

  wbBundle_t   bundle;
  logic [31:0] load_value;
  logic [31:0] wb_value;
  logic        wr_req;

  assign bundle = '{
    valid:     memValid,
    rdAddr:    memRdAddr,
    rdWE:      memRdWE,
    wbSel:     wbSel_t'(memWbSel),
    funct3:    memFunct3,
    addrLow:   memAddrLow,
    readData:  memReadData,
    aluResult: memAluResult,
    immediate: memImmediate
  };

  jzjpcc_loadextract u_loadextract (
    .funct3  (bundle.funct3),
    .addrLow (bundle.addrLow),
    .word    (bundle.readData),
    .value   (load_value)
  );

  always_comb begin
    wb_value = bundle.aluResult;
    case (bundle.wbSel)
      WB_LOAD: wb_value = load_value;
      WB_IMM:  wb_value = bundle.immediate;
      default: wb_value = bundle.aluResult;   // WB_ALU and reserved
    endcase
  end

  // x0 is hardwired to zero: never written, never forwarded.
  assign wr_req = bundle.rdWE && (bundle.rdAddr != 5'd0);

  logic        valid_q;
  logic        wr_req_q;
  logic [4:0]  rd_addr_q;
  logic [31:0] rd_data_q;

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      valid_q   <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_addr_q <= 5'd0;
      rd_data_q <= 32'd0;
    end else if (flush) begin
      // Bubble: data may follow the inputs, the write is suppressed.
      valid_q   <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_addr_q <= bundle.rdAddr;
      rd_data_q <= wb_value;
    end else if (!stall) begin
      valid_q   <= bundle.valid;
      wr_req_q  <= wr_req;
      rd_addr_q <= bundle.rdAddr;
      rd_data_q <= wb_value;
    end
  end

  // Both terms are flops, so the write port has no path from the inputs.
  assign rdWE     = valid_q & wr_req_q;
  assign rdAddr   = rd_addr_q;
  assign rdData   = rd_data_q;
  assign fwdValid = rdWE;
  assign fwdAddr  = rd_addr_q;
  assign fwdData  = rd_data_q;

`ifdef JZJPCC_WB_RETIRE_COUNTER_EN
  logic [RETIRE_CNT_W-1:0] retire_q;

  // Counts every captured real instruction, whether or not it writes rd.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retire_q <= '0;
    end else if (!flush && !stall && bundle.valid) begin
      retire_q <= retire_q + RETIRE_CNT_W'(1);
    end
  end

  assign retireCount = retire_q;
`else
  assign retireCount = '0;
`endif

endmodule
